// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl: background scrubber for the ECC-protected FIFO storage array.
// Walks every word through the external decoder and rewrites words that held a correctable error.
module ecc_scrub_ctrl #(
  parameter int ADDR_W   = 4,
  parameter int DW       = 32,
  parameter int EW       = 7,
  parameter int INTERVAL = 1024,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scrub_en,
  output logic              scr_req,
  input  logic              scr_gnt,
  output logic              scr_we,
  output logic [ADDR_W-1:0] scr_addr,
  output logic [DW-1:0]     scr_wdata,
  output logic [EW-1:0]     scr_wecc,
  input  logic [DW-1:0]     mem_rdata,
  input  logic [EW-1:0]     mem_recc,
  output logic [DW-1:0]     dec_d_in,
  output logic [EW-1:0]     dec_ecc_in,
  input  logic [DW-1:0]     dec_d_out,
  input  logic              dec_sec,
  input  logic              dec_ded,
  output logic [DW-1:0]     enc_d_in,
  input  logic [EW-1:0]     enc_ecc,
  input  logic              fifo_wr_en,
  input  logic [ADDR_W-1:0] fifo_wr_addr,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [CNT_W-1:0]  ded_cnt,
  output logic              ded_flag,
  output logic [ADDR_W-1:0] ded_addr,
  output logic              pass_done,
  output logic              busy
);

  localparam int                IW        = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [IW-1:0]     INT_LAST  = IW'(INTERVAL - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_CHECK   = 3'd3,
    S_WB_REQ  = 3'd4,
    S_NEXT    = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IW-1:0]     icnt_q, icnt_d;
  logic [DW-1:0]     cw_data_q, cw_data_d;
  logic [EW-1:0]     cw_ecc_q, cw_ecc_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [CNT_W-1:0]  sec_cnt_q, sec_cnt_d;
  logic [CNT_W-1:0]  ded_cnt_q, ded_cnt_d;
  logic              ded_flag_q, ded_flag_d;
  logic [ADDR_W-1:0] ded_addr_q, ded_addr_d;
  logic              pass_done_q, pass_done_d;
  logic              hit_q, hit_d;
  logic              collide_s;
  logic              wb_abort_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // A FIFO write to the word in flight makes the read copy stale; hit_q remembers it.
  assign collide_s  = fifo_wr_en & (fifo_wr_addr == addr_q);
  assign wb_abort_s = collide_s | hit_q;

  assign scr_req    = (state_q == S_RD_REQ) | ((state_q == S_WB_REQ) & ~wb_abort_s);
  assign scr_we     = (state_q == S_WB_REQ);
  assign scr_addr   = addr_q;
  assign scr_wdata  = wdata_q;
  assign scr_wecc   = (state_q == S_WB_REQ) ? enc_ecc : {EW{1'b0}};
  assign enc_d_in   = wdata_q;
  assign dec_d_in   = cw_data_q;
  assign dec_ecc_in = cw_ecc_q;
  assign sec_cnt    = sec_cnt_q;
  assign ded_cnt    = ded_cnt_q;
  assign ded_flag   = ded_flag_q;
  assign ded_addr   = ded_addr_q;
  assign pass_done  = pass_done_q;
  assign busy       = (state_q != S_IDLE);

  // Next-state and datapath update for the scrub sequence.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    icnt_d      = icnt_q;
    cw_data_d   = cw_data_q;
    cw_ecc_d    = cw_ecc_q;
    wdata_d     = wdata_q;
    sec_cnt_d   = sec_cnt_q;
    ded_cnt_d   = ded_cnt_q;
    ded_flag_d  = ded_flag_q;
    ded_addr_d  = ded_addr_q;
    pass_done_d = 1'b0;
    hit_d       = hit_q;
    case (state_q)
      S_IDLE: begin
        hit_d = 1'b0;
        if (!scrub_en) begin
          icnt_d = {IW{1'b0}};
        end else if (icnt_q == INT_LAST) begin
          icnt_d  = {IW{1'b0}};
          state_d = S_RD_REQ;
        end else begin
          icnt_d = icnt_q + IW'(1);
        end
      end
      S_RD_REQ: begin
        if (scr_gnt) begin
          state_d = S_RD_WAIT;
          hit_d   = collide_s;
        end else begin
          state_d = S_RD_REQ;
        end
      end
      S_RD_WAIT: begin
        cw_data_d = mem_rdata;
        cw_ecc_d  = mem_recc;
        state_d   = S_CHECK;
        if (collide_s) begin
          hit_d = 1'b1;
        end else begin
          hit_d = hit_q;
        end
      end
      S_CHECK: begin
        // Counters record the error even when a FIFO write makes the repair unnecessary.
        if (dec_ded) begin
          ded_cnt_d  = sat_inc(ded_cnt_q);
          ded_flag_d = 1'b1;
          ded_addr_d = addr_q;
          state_d    = S_NEXT;
        end else if (dec_sec) begin
          sec_cnt_d = sat_inc(sec_cnt_q);
          wdata_d   = dec_d_out;
          if (wb_abort_s) begin
            state_d = S_NEXT;
          end else begin
            state_d = S_WB_REQ;
          end
        end else begin
          state_d = S_NEXT;
        end
      end
      S_WB_REQ: begin
        if (wb_abort_s) begin
          state_d = S_NEXT;
        end else if (scr_gnt) begin
          state_d = S_NEXT;
        end else begin
          state_d = S_WB_REQ;
        end
      end
      S_NEXT: begin
        addr_d      = addr_q + ADDR_W'(1);
        pass_done_d = (addr_q == ADDR_LAST);
        icnt_d      = {IW{1'b0}};
        hit_d       = 1'b0;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= {ADDR_W{1'b0}};
      icnt_q      <= {IW{1'b0}};
      cw_data_q   <= {DW{1'b0}};
      cw_ecc_q    <= {EW{1'b0}};
      wdata_q     <= {DW{1'b0}};
      sec_cnt_q   <= {CNT_W{1'b0}};
      ded_cnt_q   <= {CNT_W{1'b0}};
      ded_flag_q  <= 1'b0;
      ded_addr_q  <= {ADDR_W{1'b0}};
      pass_done_q <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      icnt_q      <= icnt_d;
      cw_data_q   <= cw_data_d;
      cw_ecc_q    <= cw_ecc_d;
      wdata_q     <= wdata_d;
      sec_cnt_q   <= sec_cnt_d;
      ded_cnt_q   <= ded_cnt_d;
      ded_flag_q  <= ded_flag_d;
      ded_addr_q  <= ded_addr_d;
      pass_done_q <= pass_done_d;
      hit_q       <= hit_d;
    end
  end

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Bench for ecc_scrub_ctrl: behavioural SECDED codec, storage array and FIFO around the
// scrubber; expected outcomes come from the injected error pattern of each word.
module tb_ecc_scrub_ctrl;
  localparam int AW = 4, DW = 32, EW = 7, INTERVAL = 4, CNT_W = 3, DEPTH = 16;
  localparam int WORD_CYC = INTERVAL + 4;
  localparam int CMAX = 7;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [EW-1:0] e;
  } wr_t;

  logic clk = 1'b0;
  logic rst, scrub_en, scr_req, scr_gnt, scr_we;
  logic [AW-1:0] scr_addr, fifo_wr_addr, ded_addr;
  logic [DW-1:0] scr_wdata, mem_rdata, dec_d_in, dec_d_out, enc_d_in, fifo_wdata;
  logic [EW-1:0] scr_wecc, mem_recc, dec_ecc_in, enc_ecc;
  logic dec_sec, dec_ded, fifo_wr_en, ded_flag, pass_done, busy;
  logic [CNT_W-1:0] sec_cnt, ded_cnt;
  logic gnt_en, wr_gnt_en;

  logic [DW-1:0] mem_d [DEPTH];
  logic [EW-1:0] mem_e [DEPTH];
  logic [DW-1:0] gold_d[DEPTH];
  wr_t wr_q[$];
  int rd_a_q[$];
  int rd_c_q[$];
  int pass_cnt, cyc, rd_pend, rd_addr;
  int errors, checks;

  always #5 clk = ~clk;

  ecc_scrub_ctrl #(.ADDR_W(AW), .DW(DW), .EW(EW), .INTERVAL(INTERVAL), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .scrub_en(scrub_en), .scr_req(scr_req), .scr_gnt(scr_gnt),
    .scr_we(scr_we), .scr_addr(scr_addr), .scr_wdata(scr_wdata), .scr_wecc(scr_wecc),
    .mem_rdata(mem_rdata), .mem_recc(mem_recc), .dec_d_in(dec_d_in), .dec_ecc_in(dec_ecc_in),
    .dec_d_out(dec_d_out), .dec_sec(dec_sec), .dec_ded(dec_ded), .enc_d_in(enc_d_in),
    .enc_ecc(enc_ecc), .fifo_wr_en(fifo_wr_en), .fifo_wr_addr(fifo_wr_addr),
    .sec_cnt(sec_cnt), .ded_cnt(ded_cnt), .ded_flag(ded_flag), .ded_addr(ded_addr),
    .pass_done(pass_done), .busy(busy));

  // Hamming position of data bit i: the i-th non-power-of-two in 3..38.
  function automatic logic [5:0] pos_of(input int i);
    int n;
    n = 0;
    for (int p = 3; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == i) return 6'(p);
        n++;
      end
    end
    return 6'd0;
  endfunction

  function automatic logic [EW-1:0] encode(input logic [DW-1:0] d);
    logic [5:0] s;
    s = 6'd0;
    for (int i = 0; i < DW; i++) if (d[i]) s = s ^ pos_of(i);
    return {s, (^d) ^ (^s)};
  endfunction

  function automatic logic [DW+1:0] decode(input logic [DW-1:0] d, input logic [EW-1:0] e);
    logic [EW-1:0] c;
    logic [5:0] syn;
    logic [DW-1:0] fix;
    c = encode(d);
    syn = e[6:1] ^ c[6:1];
    fix = d;
    if (^{d, e}) begin
      for (int i = 0; i < DW; i++) if (pos_of(i) == syn) fix[i] = ~fix[i];
      return {1'b1, 1'b0, fix};
    end else if (syn != 6'd0) begin
      return {1'b0, 1'b1, d};
    end
    return {2'b00, d};
  endfunction

  always_comb begin
    {dec_sec, dec_ded, dec_d_out} = decode(dec_d_in, dec_ecc_in);
    enc_ecc = encode(enc_d_in);
  end

  assign scr_gnt = scr_req & gnt_en & (~scr_we | wr_gnt_en);

  // Array/arbiter model, sampled mid-cycle.
  task automatic monitor();
    if (rd_pend != 0) begin
      mem_rdata = mem_d[rd_addr];
      mem_recc  = mem_e[rd_addr];
    end else begin
      mem_rdata = $urandom;
      mem_recc  = 7'($urandom);
    end
    rd_pend = 0;
    if (!rst && scr_req && scr_gnt) begin
      if (scr_we) begin
        mem_d[scr_addr] = scr_wdata;
        mem_e[scr_addr] = scr_wecc;
        wr_q.push_back('{scr_addr, scr_wdata, scr_wecc});
      end else begin
        rd_pend = 1;
        rd_addr = int'(scr_addr);
        rd_a_q.push_back(int'(scr_addr));
        rd_c_q.push_back(cyc);
      end
    end
    if (fifo_wr_en) begin
      mem_d[fifo_wr_addr] = fifo_wdata;
      mem_e[fifo_wr_addr] = encode(fifo_wdata);
    end
    if (!rst && pass_done) pass_cnt++;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic flip_bit(input int a, input int b);
    if (b < DW) mem_d[a][b] = ~mem_d[a][b];
    else mem_e[a][b-DW] = ~mem_e[a][b-DW];
  endtask

  task automatic load_clean();
    for (int a = 0; a < DEPTH; a++) begin
      gold_d[a] = $urandom;
      mem_d[a]  = gold_d[a];
      mem_e[a]  = encode(gold_d[a]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; scrub_en = 1'b0; fifo_wr_en = 1'b0; fifo_wr_addr = 4'd0; fifo_wdata = 32'd0;
    gnt_en = 1'b1; wr_gnt_en = 1'b1; rd_pend = 0;
    tick(); tick();
    rst = 1'b0;
    wr_q.delete(); rd_a_q.delete(); rd_c_q.delete(); pass_cnt = 0;
  endtask

  task automatic run_pass(input string name);
    int start, n;
    start = pass_cnt; n = 0;
    while (pass_cnt == start && n < 600) begin tick(); n++; end
    checks++;
    if (pass_cnt == start) begin errors++; $display("FAIL %s_pass_timeout: pass_done not seen in %0d cycles", name, n); end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 50) begin tick(); n++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle_timeout: busy=%b expected 0", name, busy); end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s: got %0h expected %0h", name, act, exp); end
  endtask

  task automatic test_reset();
    rst = 1'b1; scrub_en = 1'b1;
    #1;
    checks++;
    if ({scr_req, scr_we, scr_addr, scr_wdata, scr_wecc, dec_d_in, dec_ecc_in, enc_d_in,
         sec_cnt, ded_cnt, ded_flag, ded_addr, pass_done, busy} !== '0) begin
      errors++; $display("FAIL reset_outputs: req=%b busy=%b addr=%0h sec=%0d ded=%0d expected all 0",
                         scr_req, busy, scr_addr, sec_cnt, ded_cnt);
    end
    do_reset();
    for (int i = 0; i < 40; i++) tick();
    checks++;
    if (rd_a_q.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL disabled_idle: reads=%0d busy=%b expected 0 reads busy 0", rd_a_q.size(), busy);
    end
  endtask

  task automatic test_enable_gate();
    int n;
    do_reset(); load_clean();
    scrub_en = 1'b1; n = 0;
    while (rd_a_q.size() == 0 && n < 50) begin tick(); n++; end
    scrub_en = 1'b0;
    wait_idle("enable_gate");
    for (int i = 0; i < 40; i++) tick();
    checks++;
    if (rd_a_q.size() != 1 || scr_addr !== 4'd1) begin
      errors++; $display("FAIL enable_gate: reads=%0d addr=%0h expected 1 read addr 1", rd_a_q.size(), scr_addr);
    end
  endtask

  task automatic test_clean_pass();
    int bad_addr, bad_lat;
    do_reset(); load_clean();
    scrub_en = 1'b1;
    run_pass("clean");
    for (int i = 0; i < 3; i++) tick();
    bad_addr = 0; bad_lat = 0;
    for (int i = 0; i < rd_a_q.size(); i++) begin
      if (rd_a_q[i] != i) bad_addr++;
      if (i > 0 && rd_c_q[i] - rd_c_q[i-1] != WORD_CYC) bad_lat++;
    end
    chk("clean_reads", 64'(rd_a_q.size()), 64'd16);
    chk("clean_addr_order", 64'(bad_addr), 64'd0);
    chk("clean_word_latency", 64'(bad_lat), 64'd0);
    chk("clean_writes", 64'(wr_q.size()), 64'd0);
    chk("clean_pass_once", 64'(pass_cnt), 64'd1);
    chk("clean_counts", {sec_cnt, ded_cnt, ded_flag}, 64'd0);
  endtask

  task automatic check_writes(input string name, input int flips[DEPTH]);
    int idx, bad;
    wr_t e;
    idx = 0; bad = 0;
    for (int a = 0; a < DEPTH; a++) begin
      if (flips[a] == 1) begin
        e.a = 4'(a); e.d = gold_d[a]; e.e = encode(gold_d[a]);
        if (idx >= wr_q.size()) bad++;
        else if (wr_q[idx] !== e) begin
          bad++; $display("FAIL %s_write: got a=%0h d=%0h e=%0h expected a=%0h d=%0h e=%0h",
                          name, wr_q[idx].a, wr_q[idx].d, wr_q[idx].e, e.a, e.d, e.e);
        end
        idx++;
      end
    end
    chk({name, "_write_count"}, 64'(wr_q.size()), 64'(idx));
    chk({name, "_write_content"}, 64'(bad), 64'd0);
  endtask

  task automatic test_sec_correct();
    int flips[DEPTH];
    int a, nsec;
    do_reset(); load_clean();
    flips = '{default: 0};
    flip_bit(5, 3); flips[5] = 1;
    repeat (2) begin
      do a = $urandom_range(15, 0); while (flips[a] != 0);
      flip_bit(a, $urandom_range(38, 0)); flips[a] = 1;
    end
    nsec = 3;
    scrub_en = 1'b1;
    run_pass("sec");
    check_writes("sec", flips);
    chk("sec_count", 64'(sec_cnt), 64'(nsec));
    chk("sec_no_ded", {ded_cnt, ded_flag}, 64'd0);
    wr_q.delete();
    run_pass("sec_rescrub");
    chk("sec_rescrub_count", 64'(sec_cnt), 64'(nsec));
    chk("sec_rescrub_writes", 64'(wr_q.size()), 64'd0);
  endtask

  task automatic test_ded();
    int b1, b2, w;
    do_reset(); load_clean();
    w = $urandom_range(8, 0);
    b1 = $urandom_range(38, 0);
    do b2 = $urandom_range(38, 0); while (b2 == b1);
    flip_bit(w, b1); flip_bit(w, b2);
    b1 = $urandom_range(31, 0);
    do b2 = $urandom_range(31, 0); while (b2 == b1);
    flip_bit(9, b1); flip_bit(9, b2);
    scrub_en = 1'b1;
    run_pass("ded");
    chk("ded_count", 64'(ded_cnt), 64'd2);
    chk("ded_flag", 64'(ded_flag), 64'd1);
    chk("ded_addr", 64'(ded_addr), 64'd9);
    chk("ded_no_write", 64'(wr_q.size()), 64'd0);
    chk("ded_no_sec", 64'(sec_cnt), 64'd0);
  endtask

  task automatic test_saturation();
    int flips[DEPTH];
    do_reset(); load_clean();
    for (int a = 0; a < DEPTH; a++) begin flip_bit(a, $urandom_range(38, 0)); flips[a] = 1; end
    scrub_en = 1'b1;
    run_pass("sat");
    check_writes("sat", flips);
    chk("sat_count", 64'(sec_cnt), 64'((DEPTH < CMAX) ? DEPTH : CMAX));
  endtask

  task automatic test_gnt_stall();
    int n, bad;
    do_reset(); load_clean();
    flip_bit(0, $urandom_range(38, 0));
    gnt_en = 1'b0; scrub_en = 1'b1; n = 0;
    while (!scr_req && n < 50) begin tick(); n++; end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if ({scr_req, scr_we, scr_addr} !== {1'b1, 1'b0, 4'd0}) bad++;
      tick();
    end
    chk("stall_rd_stable", 64'(bad), 64'd0);
    chk("stall_rd_no_xfer", 64'(rd_a_q.size()), 64'd0);
    gnt_en = 1'b1; tick(); gnt_en = 1'b0;
    chk("stall_rd_single", 64'(rd_a_q.size()), 64'd1);
    n = 0;
    while (!(scr_req && scr_we) && n < 10) begin tick(); n++; end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if ({scr_req, scr_we, scr_addr, scr_wdata, scr_wecc} !==
          {1'b1, 1'b1, 4'd0, gold_d[0], encode(gold_d[0])}) bad++;
      tick();
    end
    chk("stall_wb_stable", 64'(bad), 64'd0);
    chk("stall_wb_no_xfer", 64'(wr_q.size()), 64'd0);
    gnt_en = 1'b1; tick(); tick(); tick();
    chk("stall_wb_single", 64'(wr_q.size()), 64'd1);
    chk("stall_no_extra_read", 64'(rd_a_q.size()), 64'd1);
  endtask

  task automatic test_collision();
    int n;
    do_reset(); load_clean();
    flip_bit(2, $urandom_range(38, 0));
    scrub_en = 1'b1; n = 0;
    while (!(scr_req && scr_gnt && !scr_we && scr_addr == 4'd2) && n < 100) begin tick(); n++; end
    tick(); tick();
    fifo_wr_en = 1'b1; fifo_wr_addr = 4'd2; fifo_wdata = $urandom; gold_d[2] = fifo_wdata;
    tick();
    fifo_wr_en = 1'b0;
    wait_idle("coll_check");
    chk("coll_check_no_write", 64'(wr_q.size()), 64'd0);
    chk("coll_check_sec", 64'(sec_cnt), 64'd1);
    chk("coll_check_addr", 64'(scr_addr), 64'd3);
    flip_bit(4, $urandom_range(38, 0));
    n = 0;
    while (!(scr_req && scr_we) && n < 50) begin tick(); n++; end
    fifo_wr_en = 1'b1; fifo_wr_addr = 4'd4; fifo_wdata = $urandom; gold_d[4] = fifo_wdata;
    #1;
    chk("coll_wb_req_drop", 64'(scr_req), 64'd0);
    tick();
    fifo_wr_en = 1'b0;
    wait_idle("coll_wb");
    chk("coll_wb_no_write", 64'(wr_q.size()), 64'd0);
    chk("coll_wb_sec", 64'(sec_cnt), 64'd2);
    chk("coll_wb_addr", 64'(scr_addr), 64'd5);
  endtask

  task automatic test_rst_midop();
    int n;
    do_reset(); load_clean();
    flip_bit(0, $urandom_range(38, 0));
    wr_gnt_en = 1'b0; scrub_en = 1'b1; n = 0;
    while (!(scr_req && scr_we) && n < 50) begin tick(); n++; end
    chk("rst_reached_wb", 64'(scr_we), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_req_drop", 64'(scr_req), 64'd0);
    chk("rst_outputs", 64'({scr_we, scr_addr, scr_wecc, sec_cnt, ded_cnt, ded_flag, busy, pass_done}), 64'd0);
    chk("rst_wdata", 64'(scr_wdata), 64'd0);
    tick(); tick();
    rst = 1'b0; wr_gnt_en = 1'b1; rd_a_q.delete();
    n = 0;
    while (rd_a_q.size() == 0 && n < 50) begin tick(); n++; end
    chk("rst_no_write", 64'(wr_q.size()), 64'd0);
    chk("rst_restart_addr", 64'((rd_a_q.size() > 0) ? rd_a_q[0] : -1), 64'd0);
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; pass_cnt = 0; rd_pend = 0; rd_addr = 0;
    rst = 1'b1; scrub_en = 1'b0; fifo_wr_en = 1'b0; fifo_wr_addr = 4'd0; fifo_wdata = 32'd0;
    gnt_en = 1'b1; wr_gnt_en = 1'b1; mem_rdata = 32'd0; mem_recc = 7'd0;
    test_reset();
    test_enable_gate();
    test_clean_pass();
    test_sec_correct();
    test_ded();
    test_saturation();
    test_gnt_stall();
    test_collision();
    test_rst_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
